// File: rtl/bus_arbiter16_pkg.sv
// rtl/bus_arbiter16_pkg.sv - shared types and constants for the CPU16/secondary bus arbiter
package bus16_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HOLD_WAIT = 2'd1,
    ST_GRANT     = 2'd2,
    ST_COOLDOWN  = 2'd3
  } arb_state_e;

  // Values driven on bus_owner
  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_M1  = 1'b1;

  // Width of the burst and cooldown counters
  localparam int CNT_W = 8;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/bus_arbiter16_if.sv
// rtl/bus_arbiter16_if.sv - master/decoder-side signal bundle of the bus arbiter
interface bus_arbiter16_if;

  // CPU16 side
  logic [15:0] cpu_addr;
  logic [15:0] cpu_dout;
  logic        cpu_we;
  logic        cpu_hold;
  logic        cpu_busy;

  // Secondary master side
  logic        m1_req;
  logic        m1_gnt;
  logic [15:0] m1_addr;
  logic [15:0] m1_dout;
  logic        m1_we;
  logic        m1_rvalid;

  // Memory-map decoder side
  logic [15:0] bus_addr;
  logic [15:0] bus_dout;
  logic        bus_we;
  logic        bus_owner;

  // View of the requesting masters and the decoder
  modport master (
    output cpu_addr, cpu_dout, cpu_we, cpu_busy,
    output m1_req, m1_addr, m1_dout, m1_we,
    input  cpu_hold, m1_gnt, m1_rvalid,
    input  bus_addr, bus_dout, bus_we, bus_owner
  );

  // View of the arbiter
  modport slave (
    input  cpu_addr, cpu_dout, cpu_we, cpu_busy,
    input  m1_req, m1_addr, m1_dout, m1_we,
    output cpu_hold, m1_gnt, m1_rvalid,
    output bus_addr, bus_dout, bus_we, bus_owner
  );

endinterface

// File: rtl/bus_arbiter16.sv
// rtl/bus_arbiter16.sv - shares the 16-bit system bus between CPU16 and one secondary master
module bus_arbiter16
  import bus16_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int MIN_CPU   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  bus_arbiter16_if.slave        bus
);

  localparam cnt_t BURST_LAST = cnt_t'(MAX_BURST - 1);
  localparam cnt_t CD_LAST    = cnt_t'(MIN_CPU - 1);

  arb_state_e state_q, state_d;
  cnt_t       burst_cnt_q, burst_cnt_d;
  cnt_t       cd_cnt_q, cd_cnt_d;
  logic       cpu_hold_q, cpu_hold_d;
  logic       m1_gnt_q, m1_gnt_d;
  logic       owner_q, owner_d;
  logic       m1_rvalid_q, m1_rvalid_d;

  // Next-state, counter and registered-output logic
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    cd_cnt_d    = cd_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.m1_req) state_d = ST_HOLD_WAIT;
      end
      ST_HOLD_WAIT: begin
        if (!bus.m1_req) begin
          state_d = ST_IDLE;
        end else if (!bus.cpu_busy) begin
          state_d     = ST_GRANT;
          burst_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        burst_cnt_d = burst_cnt_q + 1'b1;
        // A request drop takes priority over burst expiry: no cooldown then
        if (!bus.m1_req) begin
          state_d = ST_IDLE;
        end else if (burst_cnt_q == BURST_LAST) begin
          state_d  = ST_COOLDOWN;
          cd_cnt_d = '0;
        end
      end
      ST_COOLDOWN: begin
        if (cd_cnt_q == CD_LAST) state_d = ST_IDLE;
        else                     cd_cnt_d = cd_cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered copies of the state being entered
    cpu_hold_d  = (state_d == ST_HOLD_WAIT) || (state_d == ST_GRANT);
    m1_gnt_d    = (state_d == ST_GRANT);
    owner_d     = (state_d == ST_GRANT) ? OWNER_M1 : OWNER_CPU;
    // The synchronous memory answers a granted read one cycle later
    m1_rvalid_d = m1_gnt_q && !bus.m1_we;
  end

  // State, counter and output registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      burst_cnt_q <= '0;
      cd_cnt_q    <= '0;
      cpu_hold_q  <= 1'b0;
      m1_gnt_q    <= 1'b0;
      owner_q     <= OWNER_CPU;
      m1_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      cd_cnt_q    <= cd_cnt_d;
      cpu_hold_q  <= cpu_hold_d;
      m1_gnt_q    <= m1_gnt_d;
      owner_q     <= owner_d;
      m1_rvalid_q <= m1_rvalid_d;
    end
  end

  // Bus mux driven by the registered owner; m1 writes only while granted
  always_comb begin
    bus.bus_addr = bus.cpu_addr;
    bus.bus_dout = bus.cpu_dout;
    bus.bus_we   = bus.cpu_we;
    if (owner_q == OWNER_M1) begin
      bus.bus_addr = bus.m1_addr;
      bus.bus_dout = bus.m1_dout;
      bus.bus_we   = bus.m1_we && m1_gnt_q;
    end
  end

  assign bus.cpu_hold  = cpu_hold_q;
  assign bus.m1_gnt    = m1_gnt_q;
  assign bus.m1_rvalid = m1_rvalid_q;
  assign bus.bus_owner = owner_q;

endmodule
